// File: rtl/op_issue_queue_pkg.sv
// Shared decoded-op definitions: opcode encodings, field layout and queue control states.
// Used by the decoder, the op issue queue and the issue stage.
package op_issue_queue_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned FLAG_W     = 3;
  localparam int unsigned DEF_OP_W   = 5;
  localparam int unsigned DEF_IMM_W  = 32;

  typedef enum logic [DEF_OP_W-1:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_SLL   = 5'd5,
    OP_SRL   = 5'd6,
    OP_SRA   = 5'd7,
    OP_SLT   = 5'd8,
    OP_LUI   = 5'd9,
    OP_LD    = 5'd16,
    OP_ST    = 5'd17,
    OP_BEQ   = 5'd20,
    OP_BNE   = 5'd21,
    OP_JAL   = 5'd24,
    OP_JALR  = 5'd25,
    OP_FENCE = 5'd30
  } opcode_e;

  // Dequeue side is either running or held behind a serialising op.
  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_BLOCKED = 1'b1
  } block_state_e;

  // Stored entry: {op, rd, rs1, rs2, imm, branch, ls, use_imm}.
  function automatic int unsigned entry_w(input int unsigned op_w, input int unsigned imm_w);
    return op_w + 3 * REG_W + imm_w + FLAG_W;
  endfunction

endpackage

// File: rtl/op_issue_queue_if.sv
// Decoder-to-issue handshake bundle: enqueue side from the decoder, dequeue side to issue.
// The queue connects through the slave modport, the decoder/issue pair through master.
interface op_issue_queue_if #(
  parameter int unsigned OP_W  = 5,
  parameter int unsigned IMM_W = 32
);
  import op_issue_queue_pkg::*;

  logic             enq_valid_in;
  logic             enq_ready_out;
  logic [OP_W-1:0]  enq_op_in;
  logic [REG_W-1:0] enq_rd_in;
  logic [REG_W-1:0] enq_rs1_in;
  logic [REG_W-1:0] enq_rs2_in;
  logic [IMM_W-1:0] enq_imm_in;
  logic             enq_branch_in;
  logic             enq_ls_in;
  logic             enq_use_imm_in;

  logic             deq_valid_out;
  logic             deq_ready_in;
  logic [OP_W-1:0]  deq_op_out;
  logic [REG_W-1:0] deq_rd_out;
  logic [REG_W-1:0] deq_rs1_out;
  logic [REG_W-1:0] deq_rs2_out;
  logic [IMM_W-1:0] deq_imm_out;
  logic             deq_branch_out;
  logic             deq_ls_out;
  logic             deq_use_imm_out;

  modport slave (
    input  enq_valid_in, enq_op_in, enq_rd_in, enq_rs1_in, enq_rs2_in, enq_imm_in,
    input  enq_branch_in, enq_ls_in, enq_use_imm_in, deq_ready_in,
    output enq_ready_out, deq_valid_out, deq_op_out, deq_rd_out, deq_rs1_out,
    output deq_rs2_out, deq_imm_out, deq_branch_out, deq_ls_out, deq_use_imm_out
  );

  modport master (
    output enq_valid_in, enq_op_in, enq_rd_in, enq_rs1_in, enq_rs2_in, enq_imm_in,
    output enq_branch_in, enq_ls_in, enq_use_imm_in, deq_ready_in,
    input  enq_ready_out, deq_valid_out, deq_op_out, deq_rd_out, deq_rs1_out,
    input  deq_rs2_out, deq_imm_out, deq_branch_out, deq_ls_out, deq_use_imm_out
  );

endinterface

// File: rtl/op_queue_mem.sv
// Entry storage for the op issue queue: one write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the queue's pointers and count.
module op_queue_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 55
) (
  input  logic                     clk_in,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/op_issue_queue.sv
// In-order decoded-op queue between decoder and issue stage, with flush, almost-full
// and a dequeue stall after a serialising op that holds until resume_in.
module op_issue_queue
  import op_issue_queue_pkg::*;
#(
  parameter int unsigned     DEPTH     = 16,
  parameter int unsigned     OP_W      = 5,
  parameter int unsigned     IMM_W     = 32,
  parameter logic [OP_W-1:0] SERIAL_OP = OP_W'(OP_JALR),
  parameter int unsigned     AF_MARGIN = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic                   resume_in,
  op_issue_queue_if.slave        q,
  output logic                   block_out,
  output logic                   full_out,
  output logic                   almost_full_out,
  output logic [$clog2(DEPTH):0] count_out
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned COUNT_W = PTR_W + 1;
  localparam int unsigned ENTRY_W = entry_w(OP_W, IMM_W);

  block_state_e       state_q, state_d;
  logic [PTR_W-1:0]   front_q, rear_q;
  logic [COUNT_W-1:0] count_q;

  logic [ENTRY_W-1:0] wr_entry, rd_entry;
  logic [OP_W-1:0]    head_op;
  logic [REG_W-1:0]   head_rd, head_rs1, head_rs2;
  logic [IMM_W-1:0]   head_imm;
  logic               head_branch, head_ls, head_use_imm;

  logic full, deq_valid, enq_fire, deq_fire, serial_fire;

  // Handshake qualification; enq_ready depends on occupancy only.
  assign full        = (count_q == COUNT_W'(DEPTH));
  assign deq_valid   = (count_q != '0) && (state_q == ST_RUN);
  assign enq_fire    = rdy_in && q.enq_valid_in && !full;
  assign deq_fire    = rdy_in && deq_valid && q.deq_ready_in;
  assign serial_fire = deq_fire && (head_op == SERIAL_OP);

  assign wr_entry = {q.enq_op_in, q.enq_rd_in, q.enq_rs1_in, q.enq_rs2_in,
                     q.enq_imm_in, q.enq_branch_in, q.enq_ls_in, q.enq_use_imm_in};

  assign {head_op, head_rd, head_rs1, head_rs2,
          head_imm, head_branch, head_ls, head_use_imm} = rd_entry;

  op_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk_in  (clk_in),
    .wr_en   (enq_fire && !flush_in),
    .wr_addr (rear_q),
    .wr_data (wr_entry),
    .rd_addr (front_q),
    .rd_data (rd_entry)
  );

  // Block state: a serialising dequeue stalls the head until resume; flush always clears.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (serial_fire) begin
          state_d = ST_BLOCKED;
        end
      end
      ST_BLOCKED: begin
        if (rdy_in && resume_in) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (flush_in) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointers wrap naturally at DEPTH; count is kept separately for exact full/empty.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      front_q <= '0;
      rear_q  <= '0;
      count_q <= '0;
    end else if (flush_in) begin
      front_q <= '0;
      rear_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_fire) begin
        rear_q <= rear_q + PTR_W'(1);
      end
      if (deq_fire) begin
        front_q <= front_q + PTR_W'(1);
      end
      count_q <= count_q + COUNT_W'(enq_fire) - COUNT_W'(deq_fire);
    end
  end

  assign q.enq_ready_out = !full;
  assign q.deq_valid_out = deq_valid;

  // Head fields are forced to zero whenever nothing is presented.
  assign q.deq_op_out      = deq_valid ? head_op      : '0;
  assign q.deq_rd_out      = deq_valid ? head_rd      : '0;
  assign q.deq_rs1_out     = deq_valid ? head_rs1     : '0;
  assign q.deq_rs2_out     = deq_valid ? head_rs2     : '0;
  assign q.deq_imm_out     = deq_valid ? head_imm     : '0;
  assign q.deq_branch_out  = deq_valid && head_branch;
  assign q.deq_ls_out      = deq_valid && head_ls;
  assign q.deq_use_imm_out = deq_valid && head_use_imm;

  assign block_out       = (state_q == ST_BLOCKED);
  assign full_out        = full;
  assign almost_full_out = (count_q >= COUNT_W'(DEPTH - AF_MARGIN));
  assign count_out       = count_q;

endmodule

// File: tb/tb_op_issue_queue.sv
// Bench for op_issue_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_op_issue_queue;
  import op_issue_queue_pkg::*;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned OP_W      = 5;
  localparam int unsigned IMM_W     = 32;
  localparam int unsigned AF_MARGIN = 2;

  logic       clk_in = 1'b0;
  logic       rst_in, rdy_in, flush_in, resume_in;
  logic       block_out, full_out, almost_full_out;
  logic [4:0] count_out;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  op_issue_queue_if #(.OP_W(OP_W), .IMM_W(IMM_W)) qif ();

  op_issue_queue #(
    .DEPTH     (DEPTH),
    .OP_W      (OP_W),
    .IMM_W     (IMM_W),
    .SERIAL_OP (OP_W'(OP_JALR)),
    .AF_MARGIN (AF_MARGIN)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .flush_in        (flush_in),
    .resume_in       (resume_in),
    .q               (qif.slave),
    .block_out       (block_out),
    .full_out        (full_out),
    .almost_full_out (almost_full_out),
    .count_out       (count_out)
  );

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        br;
    logic        ls;
    logic        ui;
  } mop_t;

  mop_t mq[$];
  bit   mblock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain queue of ops plus a blocked flag, advanced on each clock.
  always @(posedge clk_in or negedge rst_in) begin : model_upd
    bit   e, d, s, r;
    mop_t n;
    if (!rst_in) begin
      mq.delete();
      mblock = 0;
    end else if (flush_in) begin
      mq.delete();
      mblock = 0;
    end else if (rdy_in) begin
      e = qif.enq_valid_in && (mq.size() < DEPTH);
      d = qif.deq_ready_in && (mq.size() != 0) && !mblock;
      s = 0;
      if (d) s = (mq[0].op == OP_JALR);
      r = mblock && resume_in;
      n = '{op: qif.enq_op_in, rd: qif.enq_rd_in, rs1: qif.enq_rs1_in, rs2: qif.enq_rs2_in,
            imm: qif.enq_imm_in, br: qif.enq_branch_in, ls: qif.enq_ls_in, ui: qif.enq_use_imm_in};
      if (d) void'(mq.pop_front());
      if (e) mq.push_back(n);
      if (s) mblock = 1;
      else if (r) mblock = 0;
    end
  end

  task automatic compare_all();
    mop_t h;
    bit   v;
    int   n;
    n = mq.size();
    v = (n != 0) && !mblock;
    h = '0;
    if (v) h = mq[0];
    chk("count", count_out, n);
    chk("full", full_out, n == DEPTH);
    chk("almost_full", almost_full_out, n >= DEPTH - AF_MARGIN);
    chk("enq_ready", qif.enq_ready_out, n < DEPTH);
    chk("block", block_out, mblock);
    chk("deq_valid", qif.deq_valid_out, v);
    chk("deq_op", qif.deq_op_out, h.op);
    chk("deq_rd", qif.deq_rd_out, h.rd);
    chk("deq_rs1", qif.deq_rs1_out, h.rs1);
    chk("deq_rs2", qif.deq_rs2_out, h.rs2);
    chk("deq_imm", qif.deq_imm_out, h.imm);
    chk("deq_flags", {qif.deq_branch_out, qif.deq_ls_out, qif.deq_use_imm_out}, {h.br, h.ls, h.ui});
  endtask

  always @(negedge clk_in) compare_all();

  task automatic drive_enq(input logic [4:0] op, input logic [31:0] imm);
    qif.enq_valid_in   = 1'b1;
    qif.enq_op_in      = op;
    qif.enq_rd_in      = 5'($urandom);
    qif.enq_rs1_in     = 5'($urandom);
    qif.enq_rs2_in     = 5'($urandom);
    qif.enq_imm_in     = imm;
    qif.enq_branch_in  = 1'($urandom);
    qif.enq_ls_in      = 1'($urandom);
    qif.enq_use_imm_in = 1'($urandom);
  endtask

  task automatic idle_enq();
    qif.enq_valid_in = 1'b0;
  endtask

  initial begin
    int exp_head;
    int tag;
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; resume_in = 1'b0;
    drive_enq(OP_ADD, 0);
    idle_enq();
    qif.deq_ready_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("rst_count", count_out, 0);
    chk("rst_enq_ready", qif.enq_ready_out, 1);
    chk("rst_deq_valid", qif.deq_valid_out, 0);
    rst_in = 1'b1;

    // Fill to DEPTH with imm tags 0..15
    for (int i = 0; i < 16; i++) begin
      drive_enq(OP_ADD, 32'(i));
      @(negedge clk_in);
      chk("fill_count", count_out, i + 1);
      chk("fill_af", almost_full_out, (i + 1) >= 14);
    end
    chk("fill_full", full_out, 1);
    chk("fill_enq_ready", qif.enq_ready_out, 0);
    drive_enq(OP_ADD, 99);
    @(negedge clk_in);
    chk("no_17th", count_out, 16);

    // Full with both sides active: only the dequeue happens
    drive_enq(OP_ADD, 16);
    qif.deq_ready_in = 1'b1;
    @(negedge clk_in);
    chk("full_deq_count", count_out, 15);
    chk("full_deq_head", qif.deq_imm_out, 1);
    qif.deq_ready_in = 1'b0;
    @(negedge clk_in);
    chk("refill_count", count_out, 16);

    // Drain while enqueuing 17..31 so the pointers wrap
    exp_head = 1;
    tag = 17;
    qif.deq_ready_in = 1'b1;
    for (int c = 0; c < 100 && exp_head < 32; c++) begin
      if (qif.deq_valid_out) begin
        chk("fifo_order", qif.deq_imm_out, exp_head);
        exp_head++;
      end
      if (qif.enq_ready_out && tag < 32) begin
        drive_enq(OP_ADD, 32'(tag));
        tag++;
      end else begin
        idle_enq();
      end
      @(negedge clk_in);
    end
    idle_enq();
    qif.deq_ready_in = 1'b0;
    chk("drain_done", exp_head, 32);
    chk("drain_count", count_out, 0);

    // Serialising op blocks the following ADD until resume
    drive_enq(OP_JALR, 100);
    @(negedge clk_in);
    drive_enq(OP_ADD, 101);
    @(negedge clk_in);
    idle_enq();
    qif.deq_ready_in = 1'b1;
    @(negedge clk_in);
    chk("ser_block", block_out, 1);
    chk("ser_deq_valid", qif.deq_valid_out, 0);
    chk("ser_deq_op", qif.deq_op_out, 0);
    chk("ser_count", count_out, 1);
    repeat (2) @(negedge clk_in);
    chk("ser_hold", block_out, 1);
    resume_in = 1'b1;
    @(negedge clk_in);
    resume_in = 1'b0;
    chk("resume_block", block_out, 0);
    chk("resume_valid", qif.deq_valid_out, 1);
    chk("resume_op", qif.deq_op_out, OP_ADD);
    chk("resume_imm", qif.deq_imm_out, 101);
    @(negedge clk_in);
    qif.deq_ready_in = 1'b0;
    chk("resume_drained", count_out, 0);

    // Blocked queue with 5 entries, flushed with rdy low and an enqueue pending
    drive_enq(OP_JALR, 200);
    @(negedge clk_in);
    for (int i = 0; i < 5; i++) begin
      drive_enq(OP_ADD, 32'(201 + i));
      @(negedge clk_in);
    end
    idle_enq();
    qif.deq_ready_in = 1'b1;
    @(negedge clk_in);
    qif.deq_ready_in = 1'b0;
    chk("pre_flush_count", count_out, 5);
    chk("pre_flush_block", block_out, 1);
    flush_in = 1'b1; rdy_in = 1'b0;
    drive_enq(OP_ADD, 300);
    chk("flush_enq_ready", qif.enq_ready_out, 1);
    @(negedge clk_in);
    flush_in = 1'b0; rdy_in = 1'b1;
    idle_enq();
    chk("flush_count", count_out, 0);
    chk("flush_block", block_out, 0);
    chk("flush_deq_valid", qif.deq_valid_out, 0);

    // rdy low freezes everything for three cycles
    for (int i = 0; i < 3; i++) begin
      drive_enq(OP_ADD, 32'(400 + i));
      @(negedge clk_in);
    end
    rdy_in = 1'b0;
    drive_enq(OP_ADD, 500);
    qif.deq_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("hold_count", count_out, 3);
      chk("hold_head", qif.deq_imm_out, 400);
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    idle_enq();
    chk("unhold_count", count_out, 3);
    chk("unhold_head", qif.deq_imm_out, 401);
    repeat (4) @(negedge clk_in);
    qif.deq_ready_in = 1'b0;
    chk("unhold_drained", count_out, 0);

    // Asynchronous reset between edges with 7 entries
    for (int i = 0; i < 7; i++) begin
      drive_enq(OP_SUB, 32'(600 + i));
      @(negedge clk_in);
    end
    idle_enq();
    chk("pre_rst_count", count_out, 7);
    @(posedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    chk("arst_count", count_out, 0);
    chk("arst_deq_valid", qif.deq_valid_out, 0);
    chk("arst_deq_imm", qif.deq_imm_out, 0);
    chk("arst_enq_ready", qif.enq_ready_out, 1);
    chk("arst_full", full_out, 0);
    chk("arst_af", almost_full_out, 0);
    chk("arst_block", block_out, 0);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Randomized traffic alternating fill-heavy and drain-heavy phases
    for (int c = 0; c < 4000; c++) begin
      int ep, dp;
      ep = ((c / 400) % 2 == 1) ? 85 : 40;
      dp = ((c / 400) % 2 == 1) ? 25 : 75;
      rdy_in    = ($urandom_range(0, 7) != 0);
      flush_in  = ($urandom_range(0, 99) == 0);
      resume_in = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 99) < ep) begin
        drive_enq(($urandom_range(0, 5) == 0) ? 5'(OP_JALR) : 5'($urandom), $urandom);
      end else begin
        idle_enq();
      end
      qif.deq_ready_in = ($urandom_range(0, 99) < dp);
      @(negedge clk_in);
    end
    rdy_in = 1'b1; flush_in = 1'b0; resume_in = 1'b0;
    idle_enq();
    qif.deq_ready_in = 1'b0;
    @(negedge clk_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
